// File: rtl/hack_pkg.sv
// Shared definitions for the HACK ALU: comp-field bit positions, canonical
// comp codes and the control-field type.
package hack_pkg;

  typedef logic [5:0] alu_ctl_t;

  localparam int CTL_ZX = 5;
  localparam int CTL_NX = 4;
  localparam int CTL_ZY = 3;
  localparam int CTL_NY = 2;
  localparam int CTL_F  = 1;
  localparam int CTL_NO = 0;

  localparam alu_ctl_t COMP_ZERO    = 6'h2A;
  localparam alu_ctl_t COMP_ONE     = 6'h3F;
  localparam alu_ctl_t COMP_NEG1    = 6'h3A;
  localparam alu_ctl_t COMP_X       = 6'h0C;
  localparam alu_ctl_t COMP_Y       = 6'h30;
  localparam alu_ctl_t COMP_NOT_X   = 6'h0D;
  localparam alu_ctl_t COMP_NOT_Y   = 6'h31;
  localparam alu_ctl_t COMP_NEG_X   = 6'h0F;
  localparam alu_ctl_t COMP_NEG_Y   = 6'h33;
  localparam alu_ctl_t COMP_X_INC   = 6'h1F;
  localparam alu_ctl_t COMP_Y_INC   = 6'h37;
  localparam alu_ctl_t COMP_X_DEC   = 6'h0E;
  localparam alu_ctl_t COMP_Y_DEC   = 6'h32;
  localparam alu_ctl_t COMP_X_ADD_Y = 6'h02;
  localparam alu_ctl_t COMP_X_SUB_Y = 6'h13;
  localparam alu_ctl_t COMP_Y_SUB_X = 6'h07;
  localparam alu_ctl_t COMP_X_AND_Y = 6'h00;
  localparam alu_ctl_t COMP_X_OR_Y  = 6'h15;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational HACK ALU: zero/negate each operand, add or AND, optionally
// negate the result, and derive the zero/negative flags from that result.
module hack_alu_core
  import hack_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  alu_ctl_t         ctl,
  output logic [WIDTH-1:0] o,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] xa, xb, ya, yb, r;

  always_comb begin
    xa = ctl[CTL_ZX] ? '0 : x;
    xb = ctl[CTL_NX] ? ~xa : xa;
    ya = ctl[CTL_ZY] ? '0 : y;
    yb = ctl[CTL_NY] ? ~ya : ya;
    // Carry out of the adder is intentionally dropped (modulo 2^WIDTH).
    r  = ctl[CTL_F] ? (xb + yb) : (xb & yb);
    o  = ctl[CTL_NO] ? ~r : r;
    zr = (o == '0);
    ng = o[WIDTH-1];
  end

endmodule

// File: rtl/hack_alu.sv
// HACK ALU with one registered output stage. Handshake: in_valid=1 at a rising
// edge captures the result; out_valid marks the cycle it is presented, no backpressure.
module hack_alu
  import hack_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctl,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid
);

  logic [WIDTH-1:0] core_o;
  logic             core_zr, core_ng;

  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             out_valid_q, out_valid_d;

  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .x   (x),
    .y   (y),
    .ctl (ctl),
    .o   (core_o),
    .zr  (core_zr),
    .ng  (core_ng)
  );

  // Flags are registered alongside out from the same core result, so they never disagree.
  always_comb begin
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d = core_o;
      zr_d  = core_zr;
      ng_d  = core_ng;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      zr_q        <= 1'b1;
      ng_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hack_alu.sv
// Directed and swept checks of hack_alu: reset values, arithmetic, constants,
// wrap-around, logic ops, hold behaviour and all 64 comp codes.
module tb_hack_alu;
  import hack_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] x, y;
  logic [5:0]   ctl;
  logic [W-1:0] out;
  logic         zr, ng, out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  hack_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .ctl       (ctl),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .out_valid (out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference written arithmetically: subtraction for negation, 17-bit sum truncated.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [5:0] c);
    logic [W-1:0] p, q, r;
    logic [W:0]   s;
    p = c[5] ? 16'h0000 : a;
    if (c[4]) p = 16'hFFFF - p;
    q = c[3] ? 16'h0000 : b;
    if (c[2]) q = 16'hFFFF - q;
    s = {1'b0, p} + {1'b0, q};
    r = c[1] ? s[W-1:0] : (p & q);
    if (c[0]) r = 16'hFFFF - r;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic [5:0] cv, input logic [W-1:0] exp_o);
    logic [W-1:0] e;
    exp_q.push_back(exp_o);
    @(negedge clk);
    x = xv; y = yv; ctl = cv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".out"}, 32'(out), 32'(e));
    check({tag, ".zr"}, 32'(zr), 32'(e == 16'h0000));
    check({tag, ".ng"}, 32'(ng), 32'(e[W-1]));
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic idle_cycle(input string tag, input logic [W-1:0] held);
    @(negedge clk);
    in_valid = 1'b0;
    x = W'($urandom_range(0, 16'hFFFF));
    y = W'($urandom_range(0, 16'hFFFF));
    ctl = 6'($urandom_range(0, 63));
    @(posedge clk);
    #1;
    check({tag, ".out"}, 32'(out), 32'(held));
    check({tag, ".zr"}, 32'(zr), 32'(held == 16'h0000));
    check({tag, ".ng"}, 32'(ng), 32'(held[W-1]));
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out"}, 32'(out), 32'h0);
    check({tag, ".zr"}, 32'(zr), 32'd1);
    check({tag, ".ng"}, 32'(ng), 32'd0);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] rx, ry, ex;
    rst_n = 1'b1; in_valid = 1'b0; x = '0; y = '0; ctl = '0;
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic
    apply("add",  16'h0005, 16'h0003, COMP_X_ADD_Y, 16'h0008);
    apply("x-y",  16'h0005, 16'h0003, COMP_X_SUB_Y, 16'h0002);
    apply("y-x",  16'h0005, 16'h0003, COMP_Y_SUB_X, 16'hFFFE);

    // Constants with random operands
    for (int i = 0; i < 3; i++) begin
      rx = W'($urandom_range(0, 16'hFFFF));
      ry = W'($urandom_range(0, 16'hFFFF));
      apply("const0",  rx, ry, COMP_ZERO, 16'h0000);
      apply("const1",  rx, ry, COMP_ONE,  16'h0001);
      apply("constm1", rx, ry, COMP_NEG1, 16'hFFFF);
    end

    // Wrap-around
    apply("wrap_inc_ffff", 16'hFFFF, 16'h1234, COMP_X_INC, 16'h0000);
    apply("wrap_inc_7fff", 16'h7FFF, 16'h1234, COMP_X_INC, 16'h8000);
    apply("wrap_dec_0",    16'h0000, 16'h1234, COMP_X_DEC, 16'hFFFF);

    // Logic
    apply("and",  16'h00F0, 16'h0F0F, COMP_X_AND_Y, 16'h0000);
    apply("or",   16'h00F0, 16'h0F0F, COMP_X_OR_Y,  16'h0FFF);
    apply("notx", 16'h00F0, 16'h0F0F, COMP_NOT_X,   16'hFF0F);
    apply("negy", 16'h00F0, 16'h0F0F, COMP_NEG_Y,   16'hF0F1);
    apply("alt_notx", 16'h00F0, 16'h0F0F, 6'h1A,    16'hFF0F);
    apply("alt_noty", 16'h00F0, 16'h0F0F, 6'h26,    16'hF0F0);

    // Hold: a negative result held over several idle cycles
    apply("pre_hold", 16'h0005, 16'h0003, COMP_Y_SUB_X, 16'hFFFE);
    for (int i = 0; i < 4; i++) idle_cycle("hold", 16'hFFFE);
    apply("post_hold", 16'h0010, 16'h0003, COMP_X_SUB_Y, 16'h000D);

    // Sweep all 64 codes with random operands
    for (int c = 0; c < 64; c++) begin
      rx = W'($urandom_range(0, 16'hFFFF));
      ry = W'($urandom_range(0, 16'hFFFF));
      ex = ref_alu(rx, ry, 6'(c));
      apply($sformatf("sweep_%02h", c), rx, ry, 6'(c), ex);
    end

    // Asynchronous reset mid-operation, between clock edges
    apply("pre_rst", 16'h7FFF, 16'h0000, COMP_X_INC, 16'h8000);
    @(negedge clk);
    x = 16'h0001; y = 16'h0001; ctl = COMP_X_ADD_Y; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_mid");
    @(posedge clk);
    #1 check_reset_state("reset_held");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_reset_state("post_rst_idle");
    apply("first_after_rst", 16'h0001, 16'h0001, COMP_X_ADD_Y, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
